// File: rtl/config_pkg.sv
// Shared types and constants for the serial configuration loader and its tiles.
package config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_COMMIT
    } cfg_state_e;

    localparam int CFG_DATA_W = 32;

    // Tile configuration word: eight 2-bit switch select fields, field i at [2i+1:2i]
    localparam int SEL_W      = 2;
    localparam int SEL_FIELDS = 8;
    localparam int SEL_LSB [SEL_FIELDS] = '{0, 2, 4, 6, 8, 10, 12, 14};

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first, init 0); only used when CONFIG_LOADER_CRC_EN is defined.
module crc8_serial
    import config_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else if (clr_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= crc8_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/config_loader.sv
// Serial config deserialiser driving the tile config_data bus and one-hot commit strobes.
// Optional trailing CRC-8 check per frame when CONFIG_LOADER_CRC_EN is defined.
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = CFG_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [DATA_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_enable,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic                 addr_error
`ifdef CONFIG_LOADER_CRC_EN
    ,
    output logic                 crc_error
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    cfg_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_TILES-1:0] en_q, en_d;
    logic [15:0]          fcnt_q, fcnt_d;
    logic                 aerr_q, aerr_d;
    logic                 accept, frame_done, addr_ok, crc_ok;

    assign bit_ready = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CRC);
    assign accept    = bit_valid && bit_ready;

    generate
        if (NUM_TILES >= (2 ** ADDR_W)) begin : g_full_map
            assign addr_ok = 1'b1;
        end else begin : g_part_map
            assign addr_ok = (addr_q < ADDR_W'(NUM_TILES));
        end
    endgenerate

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_rem;
    logic       cerr_q, cerr_d;

    // Clearing on COMMIT seeds the next back-to-back frame; the CRC bits themselves
    // are folded in too, so a good frame leaves a zero remainder.
    crc8_serial u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cfg_start || (state_q == ST_COMMIT)),
        .en_i  (accept && !cfg_start),
        .bit_i (bit_in),
        .crc_o (crc_rem)
    );

    assign crc_ok    = (crc8_step(crc_rem, bit_in) == 8'h00);
    assign crc_error = cerr_q;
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        data_d     = data_q;
        en_d       = '0;
        fcnt_d     = fcnt_q;
        aerr_d     = aerr_q;
        frame_done = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        cerr_d     = cerr_q;
`endif

        // A restart wins over everything, including a frame whose last bit lands now
        if (cfg_start) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            addr_d  = '0;
            shift_d = '0;
            fcnt_d  = '0;
            aerr_d  = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            cerr_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (accept) begin
                        addr_d = {addr_q[ADDR_W-2:0], bit_in};
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_DATA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        shift_d = {shift_q[DATA_W-2:0], bit_in};
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                            state_d = ST_CRC;
`else
                            frame_done = 1'b1;
                            state_d    = ST_COMMIT;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef CONFIG_LOADER_CRC_EN
                ST_CRC: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d      = '0;
                            frame_done = 1'b1;
                            state_d    = ST_COMMIT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Commit side effects are registered on the final-bit edge so data, strobe
        // and count are all visible together during the COMMIT cycle.
        if (frame_done) begin
            if (addr_ok && crc_ok) begin
                data_d = shift_d;
                en_d   = NUM_TILES'(1) << addr_q;
                fcnt_d = sat_inc16(fcnt_q);
            end
            if (!addr_ok) begin
                aerr_d = 1'b1;
            end
`ifdef CONFIG_LOADER_CRC_EN
            if (!crc_ok) begin
                cerr_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= '0;
            fcnt_q  <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            fcnt_q  <= fcnt_d;
            aerr_q  <= aerr_d;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cerr_q <= 1'b0;
        end else begin
            cerr_q <= cerr_d;
        end
    end
`endif

    assign config_data   = data_q;
    assign config_enable = en_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_count   = fcnt_q;
    assign addr_error    = aerr_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a full 16-tile instance and a 12-tile instance share stimulus.
module tb_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;

    logic        rdy0, busy0, aerr0, rdy1, busy1, aerr1;
    logic [31:0] data0, data1;
    logic [15:0] en0, fcnt0, fcnt1;
    logic [11:0] en1;
`ifdef CONFIG_LOADER_CRC_EN
    logic        cerr0, cerr1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    config_loader #(.NUM_TILES(16), .ADDR_W(4), .DATA_W(32)) u0 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy0), .config_data(data0), .config_enable(en0), .busy(busy0),
        .frame_count(fcnt0), .addr_error(aerr0)
`ifdef CONFIG_LOADER_CRC_EN
        , .crc_error(cerr0)
`endif
    );

    config_loader #(.NUM_TILES(12), .ADDR_W(4), .DATA_W(32)) u1 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy1), .config_data(data1), .config_enable(en1), .busy(busy1),
        .frame_count(fcnt1), .addr_error(aerr1)
`ifdef CONFIG_LOADER_CRC_EN
        , .crc_error(cerr1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            bit_valid = 1'b0;
            bit_in    = ~b;
            @(negedge clk);
        end
        for (int k = 0; k < 8 && !rdy0; k++) @(negedge clk);
        if (!rdy0) begin
            check_eq("ready_timeout", 32'(rdy0), 32'd1);
            return;
        end
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [31:0] d, input bit gap);
        send_bits({28'd0, a, d}, 36, gap);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_ready", 32'(rdy0), 32'd0);
        check_eq("rst_en", 32'(en0), 32'd0);
        check_eq("rst_data", data0, 32'd0);
        check_eq("rst_fcnt", 32'(fcnt0), 32'd0);
        check_eq("rst_aerr", 32'(aerr0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", 32'(rdy0), 32'd0);

        // Single frame, addr 3
        pulse_start();
        check_eq("start_busy", 32'(busy0), 32'd1);
        check_eq("start_ready", 32'(rdy0), 32'd1);
        send_frame(4'd3, 32'hDEADBEEF, 1'b0);
        check_eq("f1_en", 32'(en0), 32'h0008);
        check_eq("f1_data", data0, 32'hDEADBEEF);
        check_eq("f1_fcnt", 32'(fcnt0), 32'd1);
        check_eq("f1_ready_commit", 32'(rdy0), 32'd0);
        check_eq("f1_en12", 32'(en1), 32'h008);
        @(negedge clk);
        check_eq("f1_en_drop", 32'(en0), 32'd0);
        check_eq("f1_data_hold", data0, 32'hDEADBEEF);
        check_eq("f1_wait_busy", 32'(busy0), 32'd1);

        // Back-to-back frames with bit_valid toggling; addr 15 is out of range for u1
        pulse_start();
        send_frame(4'd0, 32'h00000005, 1'b1);
        check_eq("bb0_en", 32'(en0), 32'h0001);
        check_eq("bb0_data", data0, 32'h00000005);
        check_eq("bb0_fcnt", 32'(fcnt0), 32'd1);
        send_frame(4'd15, 32'h0000A000, 1'b1);
        check_eq("bb1_en", 32'(en0), 32'h8000);
        check_eq("bb1_data", data0, 32'h0000A000);
        check_eq("bb1_fcnt", 32'(fcnt0), 32'd2);
        check_eq("bb1_en12", 32'(en1), 32'd0);
        check_eq("bb1_data12", data1, 32'h00000005);
        check_eq("bb1_aerr12", 32'(aerr1), 32'd1);
        check_eq("bb1_aerr16", 32'(aerr0), 32'd0);
        @(negedge clk);
        check_eq("bb1_en_drop", 32'(en0), 32'd0);

        // Out-of-range address 13 on the 12-tile instance; error is sticky
        pulse_start();
        check_eq("oor_aerr_clr", 32'(aerr1), 32'd0);
        send_frame(4'd13, 32'h11111111, 1'b0);
        check_eq("oor_en12", 32'(en1), 32'd0);
        check_eq("oor_data12", data1, 32'h00000005);
        check_eq("oor_aerr12", 32'(aerr1), 32'd1);
        check_eq("oor_fcnt12", 32'(fcnt1), 32'd0);
        check_eq("oor_en16", 32'(en0), 32'h2000);
        send_frame(4'd2, 32'h0000_00F0, 1'b0);
        check_eq("oor_sticky", 32'(aerr1), 32'd1);
        check_eq("oor_next_en12", 32'(en1), 32'h004);
        check_eq("oor_next_fcnt12", 32'(fcnt1), 32'd1);

        // Abort after 20 bits, then a clean frame
        pulse_start();
        send_bits({44'd0, 4'd9, 16'hFFFF}, 20, 1'b0);
        check_eq("abort_noen", 32'(en0), 32'd0);
        pulse_start();
        check_eq("abort_busy", 32'(busy0), 32'd1);
        check_eq("abort_fcnt", 32'(fcnt0), 32'd0);
        send_frame(4'd1, 32'h12345678, 1'b0);
        check_eq("abort_f_en", 32'(en0), 32'h0002);
        check_eq("abort_f_data", data0, 32'h12345678);
        check_eq("abort_f_fcnt", 32'(fcnt0), 32'd1);

        // Async reset after 10 payload bits
        pulse_start();
        send_bits({50'd0, 4'd7, 10'h2AB}, 14, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", 32'(busy0), 32'd0);
        check_eq("mrst_ready", 32'(rdy0), 32'd0);
        check_eq("mrst_data", data0, 32'd0);
        check_eq("mrst_fcnt", 32'(fcnt0), 32'd0);
        check_eq("mrst_aerr12", 32'(aerr1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send_frame(4'd7, 32'hCAFEF00D, 1'b0);
        check_eq("mrst_f_en", 32'(en0), 32'h0080);
        check_eq("mrst_f_data", data0, 32'hCAFEF00D);
        check_eq("mrst_f_fcnt", 32'(fcnt0), 32'd1);

        // cfg_start coinciding with COMMIT
        send_frame(4'd5, 32'h0BADF00D, 1'b0);
        check_eq("cc_en", 32'(en0), 32'h0020);
        check_eq("cc_fcnt", 32'(fcnt0), 32'd2);
        pulse_start();
        check_eq("cc_fcnt_clr", 32'(fcnt0), 32'd0);
        check_eq("cc_en_drop", 32'(en0), 32'd0);
        check_eq("cc_data_hold", data0, 32'h0BADF00D);
        send_frame(4'd6, 32'h00C0FFEE, 1'b0);
        check_eq("cc_next_en", 32'(en0), 32'h0040);
        check_eq("cc_next_fcnt", 32'(fcnt0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
